pipelined_addsub_unit: RTL and testbench
========================================

# pipelined_addsub_unit

Parametrised, pipelined two's-complement add/subtract unit, successor to the fixed 16-bit ripple-carry adder. The carry chain is cut into SEG_WIDTH-bit segments, one segment per pipeline stage, giving one result per cycle at widths where a single-cycle ripple chain misses timing. Each result carries signed-overflow, carry, zero and optional saturation flags plus a sideband tag. The unit sits between the multiplier array and the accumulator in the matrix-multiplication datapath, with valid/ready handshakes on both sides.

## Interface
- BIT_WIDTH, 16: operand/result width; must be a multiple of SEG_WIDTH, at least 2.
- SEG_WIDTH, 4: bits resolved per pipeline stage; STAGES = BIT_WIDTH/SEG_WIDTH.
- TAG_WIDTH, 8: sideband tag width, passed through unchanged.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- a, b  in  BIT_WIDTH each  signed operands.
- operation  in  1  0 = a+b, 1 = a−b.
- saturate  in  1  1 = clamp on signed overflow.
- in_tag  in  TAG_WIDTH  sideband.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  BIT_WIDTH  result (saturated if requested).
- c_out  out  1  raw carry out of MSB (for subtraction, 1 = no borrow).
- overflow  out  1  signed overflow of the unsaturated result.
- zero  out  1  final sum == 0.
- out_tag  out  TAG_WIDTH  in_tag of this result.

## Operation
- Subtraction: b is inverted and carry-in is 1. The carry-in applies to segment 0 only.
- Stage k (0..STAGES−1) adds segment k of a and b_processed with the carry registered from stage k−1.
- Operand segments not yet consumed travel with the beat in skew registers. Resolved low segments are forwarded with the beat.
- A per-stage valid bit, the a/b sign bits, operation, saturate and tag travel with each beat.
- Overflow, computed at the final stage from the delayed signs:
  - add: sign(a)==sign(b) and sign(sum)!=sign(a).
  - sub: sign(a)!=sign(b) and sign(sum)!=sign(a).
- Saturation, when saturate=1 and overflow=1:
  - sum = 2^(BIT_WIDTH−1)−1 if sign(a)=0.
  - sum = −2^(BIT_WIDTH−1) if sign(a)=1.
  - overflow still reports 1; c_out stays the raw carry.
- zero is evaluated on the final (post-saturation) sum.
- Flow control is a global enable:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance=1, all stages shift by one. Bubbles (valid=0) shift like data and are not collapsed.
  - When advance=0, every stage register holds.
- A beat is accepted on in_valid && in_ready. A result is consumed on out_valid && out_ready.
- Results leave in acceptance order, with no loss and no duplication.

## Timing
- Latency: a beat accepted at edge N presents out_valid=1 after edge N+STAGES, if no stall occurs.
- Each stall cycle adds one cycle of latency.
- Throughput: one beat per cycle while out_ready=1.
- The output register is the last pipeline stage. While out_valid && !out_ready, sum, flags and out_tag are stable.
- in_ready depends combinationally on out_valid and out_ready only; there is no path from in_valid.
- On reset:
  - All valid bits clear; out_valid=0.
  - sum, c_out, overflow and out_tag are 0; zero is 0.
  - in_ready=1 after the first post-reset edge.
- Reset mid-stream discards all in-flight beats. Inputs presented during the reset cycle are not accepted.
- Simultaneous consume and accept in the same cycle is legal and keeps full throughput.
- operation and saturate are sampled per beat; changing them every cycle is legal.

## Test plan
All scenarios use BIT_WIDTH=16, SEG_WIDTH=4 (latency 4).
- Add 0x1234 + 0x0FFF, tag 0x11.
  - Expect sum=0x2233, c_out=0, overflow=0, zero=0, out_tag=0x11.
  - out_valid is asserted exactly 4 cycles after acceptance.
- Add 0xFFFF + 0x0001.
  - Expect sum=0x0000, c_out=1, overflow=0, zero=1.
  - Carry must cross all four segments.
- Sub 0x0005 − 0x0007 → sum=0xFFFE, c_out=0, overflow=0. Sub 0x0007 − 0x0007 → sum=0x0000, c_out=1, zero=1.
- Signed overflow:
  - Add 0x7FFF + 0x0001: saturate=0 gives sum=0x8000, overflow=1; saturate=1 gives sum=0x7FFF, overflow=1.
  - Sub 0x8000 − 0x0001: saturate=0 gives sum=0x7FFF; saturate=1 gives sum=0x8000; overflow=1 in both cases.
- Backpressure:
  - Stimulus: 8 back-to-back beats with tags 0..7 and mixed add/sub; hold out_ready=0 for 3 cycles while out_valid=1.
  - in_ready must be 0 during the stall. The held output must be stable.
  - All 8 results must arrive in tag order with correct values, none lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst for one cycle with 3 beats in flight.
  - Next cycle: out_valid=0 and sum=0.
  - No pre-reset tag may appear afterwards. A new beat accepted after reset completes normally in 4 cycles.

Source files
------------

// File: rtl/pipelined_addsub_unit.sv
// Segmented-carry two's-complement add/subtract with saturation, flags and a sideband tag.
// Latency: STAGES+1 edges from acceptance to out_valid (STAGES segment ranks plus the output rank).
// Backpressure: a global enable stalls every rank while out_valid && !out_ready; in_ready mirrors it.
module pipelined_addsub_unit #(
    parameter int BIT_WIDTH = 16,
    parameter int SEG_WIDTH = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 operation,
    input  logic                 saturate,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 c_out,
    output logic                 overflow,
    output logic                 zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int STAGES = BIT_WIDTH / SEG_WIDTH;
    localparam int MSB    = BIT_WIDTH - 1;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // LEFT: operand bits still unresolved on entry; REM: bits still unresolved on exit.
            localparam int LEFT = BIT_WIDTH - k * SEG_WIDTH;
            localparam int REM  = LEFT - SEG_WIDTH;
            localparam int DONE = (k + 1) * SEG_WIDTH;

            logic [LEFT-1:0]      a_rest;
            logic [LEFT-1:0]      b_rest;
            logic                 cin;
            logic                 v_src;
            logic                 sa_src;
            logic                 sb_src;
            logic                 sat_src;
            logic [TAG_WIDTH-1:0] tag_src;
            logic [SEG_WIDTH:0]   seg_sum;
            logic [DONE-1:0]      r_next;

            logic                 vld_q;
            logic                 c_q;
            logic                 sa_q;
            logic                 sb_q;
            logic                 sat_q;
            logic [TAG_WIDTH-1:0] tag_q;
            logic [DONE-1:0]      r_q;

            if (k == 0) begin : g_first
                logic [BIT_WIDTH-1:0] b_proc;

                assign b_proc  = operation ? ~b : b;
                assign a_rest  = a;
                assign b_rest  = b_proc;
                assign cin     = operation;
                assign v_src   = in_valid;
                assign sa_src  = a[MSB];
                assign sb_src  = b_proc[MSB];
                assign sat_src = saturate;
                assign tag_src = in_tag;
                assign r_next  = seg_sum[SEG_WIDTH-1:0];
            end else begin : g_next
                assign a_rest  = g_stage[k-1].g_skew.a_q;
                assign b_rest  = g_stage[k-1].g_skew.b_q;
                assign cin     = g_stage[k-1].c_q;
                assign v_src   = g_stage[k-1].vld_q;
                assign sa_src  = g_stage[k-1].sa_q;
                assign sb_src  = g_stage[k-1].sb_q;
                assign sat_src = g_stage[k-1].sat_q;
                assign tag_src = g_stage[k-1].tag_q;
                assign r_next  = {seg_sum[SEG_WIDTH-1:0], g_stage[k-1].r_q};
            end

            assign seg_sum = {1'b0, a_rest[SEG_WIDTH-1:0]}
                           + {1'b0, b_rest[SEG_WIDTH-1:0]}
                           + {{SEG_WIDTH{1'b0}}, cin};

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    c_q   <= 1'b0;
                    sa_q  <= 1'b0;
                    sb_q  <= 1'b0;
                    sat_q <= 1'b0;
                    tag_q <= '0;
                    r_q   <= '0;
                end else if (advance) begin
                    vld_q <= v_src;
                    c_q   <= seg_sum[SEG_WIDTH];
                    sa_q  <= sa_src;
                    sb_q  <= sb_src;
                    sat_q <= sat_src;
                    tag_q <= tag_src;
                    r_q   <= r_next;
                end
            end

            // Skew registers exist only while there are segments left to resolve.
            if (REM > 0) begin : g_skew
                logic [REM-1:0] a_q;
                logic [REM-1:0] b_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (advance) begin
                        a_q <= a_rest[LEFT-1:SEG_WIDTH];
                        b_q <= b_rest[LEFT-1:SEG_WIDTH];
                    end
                end
            end
        end
    endgenerate

    logic [BIT_WIDTH-1:0] raw_sum;
    logic [BIT_WIDTH-1:0] sat_sum;
    logic [BIT_WIDTH-1:0] fin_sum;
    logic                 l_vld;
    logic                 l_c;
    logic                 l_sa;
    logic                 l_sb;
    logic                 l_sat;
    logic [TAG_WIDTH-1:0] l_tag;
    logic                 ovf;

    assign raw_sum = g_stage[STAGES-1].r_q;
    assign l_vld   = g_stage[STAGES-1].vld_q;
    assign l_c     = g_stage[STAGES-1].c_q;
    assign l_sa    = g_stage[STAGES-1].sa_q;
    assign l_sb    = g_stage[STAGES-1].sb_q;
    assign l_sat   = g_stage[STAGES-1].sat_q;
    assign l_tag   = g_stage[STAGES-1].tag_q;

    // l_sb is the sign of the already-inverted b for subtraction, so one rule covers add and sub.
    assign ovf     = (l_sa == l_sb) && (raw_sum[MSB] != l_sa);
    assign sat_sum = l_sa ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : {1'b0, {(BIT_WIDTH-1){1'b1}}};
    assign fin_sum = (l_sat && ovf) ? sat_sum : raw_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= l_vld;
            sum       <= fin_sum;
            c_out     <= l_c;
            overflow  <= ovf;
            zero      <= (fin_sum == '0);
            out_tag   <= l_tag;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Directed bench for pipelined_addsub_unit at 16-bit width, 4-bit segments.
module tb_pipelined_addsub_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        operation;
    logic        saturate;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;
    logic        zero;
    logic [7:0]  out_tag;

    int tests  = 0;
    int failed = 0;

    pipelined_addsub_unit #(.BIT_WIDTH(16), .SEG_WIDTH(4), .TAG_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .operation(operation), .saturate(saturate), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out),
        .overflow(overflow), .zero(zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic run_beat(input string name, input logic [15:0] ai, input logic [15:0] bi,
                            input logic op, input logic sat, input logic [7:0] tg,
                            input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ai; b = bi; operation = op; saturate = sat; in_tag = tg;
        #1 check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_c_out"}, 32'(c_out), 32'(ec));
        check({name, "_overflow"}, 32'(overflow), 32'(eo));
        check({name, "_zero"}, 32'(zero), 32'(ez));
        check({name, "_tag"}, 32'(out_tag), 32'(tg));
    endtask

    // Backpressure vectors, tags 0..7, expected values worked by hand.
    logic [15:0] bp_a   [8] = '{16'h0001, 16'h0010, 16'h00FF, 16'h0000, 16'h8000, 16'h1000, 16'hABCD, 16'h7FFF};
    logic [15:0] bp_b   [8] = '{16'h0002, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0800, 16'h1111, 16'hFFFF};
    logic        bp_op  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        bp_sat [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] bp_es  [8] = '{16'h0003, 16'h000F, 16'h0100, 16'hFFFF, 16'h0000, 16'h0800, 16'hBCDE, 16'h7FFF};
    logic        bp_ec  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        bp_eo  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        bp_ez  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    int          tx;
    int          rx;
    int          stall_cnt;
    int          seen;
    logic [15:0] held_sum;
    logic [7:0]  held_tag;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; operation = 1'b0; saturate = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_c_out", 32'(c_out), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        run_beat("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 8'h11, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_beat("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_beat("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 8'h13, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_beat("sub_equal", 16'h0007, 16'h0007, 1'b1, 1'b0, 8'h14, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_beat("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 8'h15, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_beat("add_ovf_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 8'h16, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_beat("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 8'h17, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_beat("sub_ovf_sat", 16'h8000, 16'h0001, 1'b1, 1'b1, 8'h18, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Eight back-to-back beats with a three-cycle stall once two results have drained.
        tx = 0; rx = 0; stall_cnt = 0;
        for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
            @(negedge clk);
            if (out_valid && rx == 2 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
                #1 check("bp_stall_in_ready", 32'(in_ready), 32'd0);
                if (stall_cnt == 1) begin
                    held_sum = sum;
                    held_tag = out_tag;
                end else begin
                    check("bp_hold_sum", 32'(sum), 32'(held_sum));
                    check("bp_hold_tag", 32'(out_tag), 32'(held_tag));
                end
            end else begin
                out_ready = 1'b1;
                #1;
            end
            if (out_valid && out_ready) begin
                check("bp_tag", 32'(out_tag), 32'(rx));
                check("bp_sum", 32'(sum), 32'(bp_es[rx]));
                check("bp_c_out", 32'(c_out), 32'(bp_ec[rx]));
                check("bp_overflow", 32'(overflow), 32'(bp_eo[rx]));
                check("bp_zero", 32'(zero), 32'(bp_ez[rx]));
                rx++;
            end
            if (tx < 8 && in_ready) begin
                in_valid = 1'b1; a = bp_a[tx]; b = bp_b[tx]; operation = bp_op[tx];
                saturate = bp_sat[tx]; in_tag = 8'(tx);
                tx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_received", 32'(rx), 32'd8);
        check("bp_stall_cycles", 32'(stall_cnt), 32'd3);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_no_duplicate", 32'(seen), 32'd0);

        // Reset with three beats in flight; a beat presented during reset must be dropped.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; operation = 1'b0; saturate = 1'b0; in_tag = 8'hA1;
        @(negedge clk);
        in_tag = 8'hA2;
        @(negedge clk);
        in_tag = 8'hA3;
        @(negedge clk);
        in_tag = 8'hEE;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        run_beat("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, 8'h55, 16'h0007, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
